// File: rtl/mem_arbiter.sv
// Two-client arbiter sharing one BackupMemory port between icache and dcache.
// Round-robin request grant, port locked to dcache for a full write burst, responses routed by tag MSB.
module mem_arbiter #(
  parameter int MEM_ADDR_BITS = 28,
  parameter int MEM_DATA_BITS = 128,
  parameter int MEM_TAG_BITS  = 5,
  parameter int DATA_BEATS    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ic_req_valid,
  output logic                       ic_req_ready,
  input  logic [MEM_ADDR_BITS-1:0]   ic_req_addr,
  input  logic [MEM_TAG_BITS-2:0]    ic_req_tag,
  output logic                       ic_resp_valid,
  output logic [MEM_TAG_BITS-2:0]    ic_resp_tag,
  output logic [MEM_DATA_BITS-1:0]   ic_resp_data,
  input  logic                       dc_req_valid,
  output logic                       dc_req_ready,
  input  logic                       dc_req_rw,
  input  logic [MEM_ADDR_BITS-1:0]   dc_req_addr,
  input  logic [MEM_TAG_BITS-2:0]    dc_req_tag,
  input  logic                       dc_req_data_valid,
  output logic                       dc_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                       dc_resp_valid,
  output logic [MEM_TAG_BITS-2:0]    dc_resp_tag,
  output logic [MEM_DATA_BITS-1:0]   dc_resp_data,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_req_rw,
  output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  output logic [MEM_TAG_BITS-1:0]    mem_req_tag,
  output logic                       mem_req_data_valid,
  input  logic                       mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  output logic [1:0]                 mem_req_data_offset,
  input  logic                       mem_resp_valid,
  input  logic [MEM_TAG_BITS-1:0]    mem_resp_tag,
  input  logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WDATA = 1'b1;
  localparam logic [1:0] LAST_BEAT = 2'(DATA_BEATS - 1);

  logic [0:0] state;
  logic [1:0] beat;
  logic       last_grant;
  logic       hold;
  logic       hold_id;
  logic       grant_id;
  logic       idle;
  logic       wdata;
  logic       req_fire;
  logic       data_fire;

  // A request stalled by mem_req_ready keeps its grant while its valid stays up,
  // so a late-arriving competitor cannot steal the port mid-offer.
  always_comb begin
    grant_id = dc_req_valid;
    if (hold && (hold_id ? dc_req_valid : ic_req_valid))
      grant_id = hold_id;
    else if (ic_req_valid && dc_req_valid)
      grant_id = ~last_grant;
  end

  assign idle  = (state == IDLE) && !reset;
  assign wdata = (state == WDATA) && !reset;

  assign mem_req_valid = idle && (ic_req_valid || dc_req_valid);
  assign mem_req_rw    = grant_id && dc_req_rw;
  assign mem_req_addr  = grant_id ? dc_req_addr : ic_req_addr;
  assign mem_req_tag   = {grant_id, grant_id ? dc_req_tag : ic_req_tag};
  assign ic_req_ready  = idle && !grant_id && mem_req_ready;
  assign dc_req_ready  = idle && grant_id && mem_req_ready;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign mem_req_data_valid  = wdata && dc_req_data_valid;
  assign dc_req_data_ready   = wdata && mem_req_data_ready;
  assign mem_req_data_bits   = dc_req_data_bits;
  assign mem_req_data_mask   = dc_req_data_mask;
  assign mem_req_data_offset = beat;
  assign data_fire           = mem_req_data_valid && mem_req_data_ready;

  assign ic_resp_valid = !reset && mem_resp_valid && !mem_resp_tag[MEM_TAG_BITS-1];
  assign dc_resp_valid = !reset && mem_resp_valid && mem_resp_tag[MEM_TAG_BITS-1];
  assign ic_resp_tag   = mem_resp_tag[MEM_TAG_BITS-2:0];
  assign dc_resp_tag   = mem_resp_tag[MEM_TAG_BITS-2:0];
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      beat       <= 2'd0;
      last_grant <= 1'b1;
      hold       <= 1'b0;
      hold_id    <= 1'b0;
    end else begin
      if (req_fire) begin
        last_grant <= grant_id;
        hold       <= 1'b0;
        if (grant_id && dc_req_rw) begin
          state <= WDATA;
          beat  <= 2'd0;
        end
      end else if (mem_req_valid) begin
        hold    <= 1'b1;
        hold_id <= grant_id;
      end else begin
        hold <= 1'b0;
      end
      if (data_fire) begin
        beat <= beat + 2'd1;
        if (beat == LAST_BEAT)
          state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, write lock, response routing and reset abort.
module tb_mem_arbiter;

  logic         clk;
  logic         reset;
  logic         ic_req_valid, ic_req_ready;
  logic [27:0]  ic_req_addr;
  logic [3:0]   ic_req_tag;
  logic         ic_resp_valid;
  logic [3:0]   ic_resp_tag;
  logic [127:0] ic_resp_data;
  logic         dc_req_valid, dc_req_ready, dc_req_rw;
  logic [27:0]  dc_req_addr;
  logic [3:0]   dc_req_tag;
  logic         dc_req_data_valid, dc_req_data_ready;
  logic [127:0] dc_req_data_bits;
  logic [15:0]  dc_req_data_mask;
  logic         dc_resp_valid;
  logic [3:0]   dc_resp_tag;
  logic [127:0] dc_resp_data;
  logic         mem_req_valid, mem_req_ready, mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [4:0]   mem_req_tag;
  logic         mem_req_data_valid, mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic [1:0]   mem_req_data_offset;
  logic         mem_resp_valid;
  logic [4:0]   mem_resp_tag;
  logic [127:0] mem_resp_data;

  int tests = 0;
  int fails = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
    .ic_req_addr(ic_req_addr), .ic_req_tag(ic_req_tag),
    .ic_resp_valid(ic_resp_valid), .ic_resp_tag(ic_resp_tag), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_req_tag(dc_req_tag),
    .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
    .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_tag(dc_resp_tag), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_req_data_offset(mem_req_data_offset),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs change there, checks follow a further 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mvalid"}, mem_req_valid, 1'b0);
    chk({tag, "_dvalid"}, mem_req_data_valid, 1'b0);
    chk({tag, "_icrdy"}, ic_req_ready, 1'b0);
    chk({tag, "_dcrdy"}, dc_req_ready, 1'b0);
    chk({tag, "_dcdrdy"}, dc_req_data_ready, 1'b0);
    chk({tag, "_icresp"}, ic_resp_valid, 1'b0);
    chk({tag, "_dcresp"}, dc_resp_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    ic_req_valid = 1'b1; ic_req_addr = 28'h0; ic_req_tag = 4'h0;
    dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 28'h0; dc_req_tag = 4'h0;
    dc_req_data_valid = 1'b1; dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_tag = 5'h03; mem_resp_data = '0;
    #1;
    chk_quiet("rst0");
    tick();
    tick();

    // Icache read alone, with a simultaneous icache response.
    reset = 1'b0;
    dc_req_valid = 1'b0; dc_req_data_valid = 1'b0;
    ic_req_valid = 1'b1; ic_req_addr = 28'h100; ic_req_tag = 4'h3;
    mem_resp_valid = 1'b1; mem_resp_tag = 5'h03; mem_resp_data = 128'hABC;
    #1;
    chk("ic_mvalid", mem_req_valid, 1'b1);
    chk("ic_tag", mem_req_tag, 5'h03);
    chk("ic_rw", mem_req_rw, 1'b0);
    chk("ic_addr", mem_req_addr, 28'h100);
    chk("ic_rdy", ic_req_ready, 1'b1);
    chk("ic_dcrdy", dc_req_ready, 1'b0);
    chk("icresp_v", ic_resp_valid, 1'b1);
    chk("icresp_tag", ic_resp_tag, 4'h3);
    chk("icresp_data", ic_resp_data, 128'hABC);
    chk("icresp_dcv", dc_resp_valid, 1'b0);

    // Reset again so the tie sequence starts from last_grant = dc.
    tick();
    reset = 1'b1; mem_resp_valid = 1'b0;
    tick();
    reset = 1'b0;
    ic_req_valid = 1'b1; ic_req_tag = 4'h1; ic_req_addr = 28'h200;
    dc_req_valid = 1'b1; dc_req_tag = 4'h2; dc_req_addr = 28'h300; dc_req_rw = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_tag = 5'h15; mem_resp_data = 128'h55;
    #1;
    chk("tie0_tag", mem_req_tag, 5'h01);
    chk("tie0_icrdy", ic_req_ready, 1'b1);
    chk("tie0_dcrdy", dc_req_ready, 1'b0);
    chk("dcresp_v", dc_resp_valid, 1'b1);
    chk("dcresp_icv", ic_resp_valid, 1'b0);
    chk("dcresp_tag", dc_resp_tag, 4'h5);
    chk("dcresp_data", dc_resp_data, 128'h55);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("tie1_tag", mem_req_tag, 5'h12);
    chk("tie1_addr", mem_req_addr, 28'h300);
    chk("tie1_dcrdy", dc_req_ready, 1'b1);
    chk("tie1_icrdy", ic_req_ready, 1'b0);
    tick();
    #1;
    chk("tie2_tag", mem_req_tag, 5'h01);
    tick();
    #1;
    chk("tie3_tag", mem_req_tag, 5'h12);

    // Early write data in IDLE is held off.
    tick();
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    dc_req_data_valid = 1'b1; mem_req_data_ready = 1'b1;
    #1;
    chk("early_dcdrdy", dc_req_data_ready, 1'b0);
    chk("early_dvalid", mem_req_data_valid, 1'b0);

    // Dcache write to 0x40 with a stalled beat; icache waits throughout.
    tick();
    dc_req_data_valid = 1'b0;
    dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'h40; dc_req_tag = 4'h7;
    #1;
    chk("wr_tag", mem_req_tag, 5'h17);
    chk("wr_rw", mem_req_rw, 1'b1);
    chk("wr_addr", mem_req_addr, 28'h40);
    chk("wr_dcrdy", dc_req_ready, 1'b1);
    tick();
    dc_req_valid = 1'b0; dc_req_rw = 1'b0;
    ic_req_valid = 1'b1; ic_req_tag = 4'h9;
    dc_req_data_valid = 1'b1; dc_req_data_bits = 128'hB0; dc_req_data_mask = 16'hF0F0;
    mem_req_data_ready = 1'b1;
    #1;
    chk("b0_off", mem_req_data_offset, 2'd0);
    chk("b0_dvalid", mem_req_data_valid, 1'b1);
    chk("b0_dcdrdy", dc_req_data_ready, 1'b1);
    chk("b0_bits", mem_req_data_bits, 128'hB0);
    chk("b0_mask", mem_req_data_mask, 16'hF0F0);
    chk("b0_mvalid", mem_req_valid, 1'b0);
    chk("b0_icrdy", ic_req_ready, 1'b0);
    tick();
    dc_req_data_bits = 128'hB1; mem_req_data_ready = 1'b0;
    #1;
    chk("stall_off", mem_req_data_offset, 2'd1);
    chk("stall_dcdrdy", dc_req_data_ready, 1'b0);
    chk("stall_icrdy", ic_req_ready, 1'b0);
    tick();
    mem_req_data_ready = 1'b1;
    #1;
    chk("b1_off", mem_req_data_offset, 2'd1);
    chk("b1_bits", mem_req_data_bits, 128'hB1);
    chk("b1_icrdy", ic_req_ready, 1'b0);
    tick();
    dc_req_data_bits = 128'hB2;
    #1;
    chk("b2_off", mem_req_data_offset, 2'd2);
    chk("b2_icrdy", ic_req_ready, 1'b0);
    tick();
    dc_req_data_bits = 128'hB3;
    #1;
    chk("b3_off", mem_req_data_offset, 2'd3);
    chk("b3_dcdrdy", dc_req_data_ready, 1'b1);
    chk("b3_icrdy", ic_req_ready, 1'b0);
    tick();
    #1;
    chk("post_mvalid", mem_req_valid, 1'b1);
    chk("post_tag", mem_req_tag, 5'h09);
    chk("post_icrdy", ic_req_ready, 1'b1);
    chk("post_dvalid", mem_req_data_valid, 1'b0);
    chk("post_dcdrdy", dc_req_data_ready, 1'b0);

    // Write aborted by reset after two beats.
    tick();
    ic_req_valid = 1'b0; dc_req_data_valid = 1'b0;
    dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_tag = 4'h4;
    #1;
    chk("ab_dcrdy", dc_req_ready, 1'b1);
    tick();
    dc_req_valid = 1'b0;
    dc_req_data_valid = 1'b1;
    #1;
    chk("ab_b0_off", mem_req_data_offset, 2'd0);
    tick();
    #1;
    chk("ab_b1_off", mem_req_data_offset, 2'd1);
    tick();
    reset = 1'b1;
    ic_req_valid = 1'b1; dc_req_valid = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_tag = 5'h1F;
    #1;
    chk_quiet("rstw");
    tick();
    reset = 1'b0; dc_req_valid = 1'b0; mem_resp_valid = 1'b0;
    ic_req_tag = 4'h2;
    #1;
    chk("ar_mvalid", mem_req_valid, 1'b1);
    chk("ar_tag", mem_req_tag, 5'h02);
    chk("ar_icrdy", ic_req_ready, 1'b1);
    chk("ar_dvalid", mem_req_data_valid, 1'b0);
    tick();
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_tag = 4'h6;
    #1;
    chk("ar_wr_tag", mem_req_tag, 5'h16);
    tick();
    dc_req_valid = 1'b0;
    #1;
    chk("ar_wr_off", mem_req_data_offset, 2'd0);
    chk("ar_wr_dvalid", mem_req_data_valid, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    dc_req_data_valid = 1'b0; dc_req_rw = 1'b0;

    // One icache read to make the icache the last grant, then a stalled offer.
    ic_req_valid = 1'b1; ic_req_tag = 4'h8; mem_req_ready = 1'b1;
    #1;
    chk("pre_tag", mem_req_tag, 5'h08);
    tick();
    mem_req_ready = 1'b0;
    #1;
    chk("h0_tag", mem_req_tag, 5'h08);
    chk("h0_icrdy", ic_req_ready, 1'b0);
    tick();
    dc_req_valid = 1'b1; dc_req_tag = 4'hA;
    #1;
    chk("h1_tag", mem_req_tag, 5'h08);
    chk("h1_dcrdy", dc_req_ready, 1'b0);
    tick();
    #1;
    chk("h2_tag", mem_req_tag, 5'h08);
    tick();
    mem_req_ready = 1'b1;
    #1;
    chk("h3_tag", mem_req_tag, 5'h08);
    chk("h3_icrdy", ic_req_ready, 1'b1);
    chk("h3_dcrdy", dc_req_ready, 1'b0);
    tick();
    #1;
    chk("h4_tag", mem_req_tag, 5'h1A);
    chk("h4_dcrdy", dc_req_ready, 1'b1);
    chk("h4_icrdy", ic_req_ready, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client arbiter that shares the single BackupMemory port between the instruction cache (read-only) and the data cache (read/write) inside `riscv_top`. It multiplexes request and write-data channels with round-robin fairness. It locks the port to the data cache for the full duration of a multi-beat write. It routes responses back by stealing the tag MSB as a client ID.

## Interface
Parameters:
- `MEM_ADDR_BITS`, 28: memory line address width.
- `MEM_DATA_BITS`, 128: data beat width.
- `MEM_TAG_BITS`, 5: downstream tag width. Client tags are `MEM_TAG_BITS-1` bits wide.
- `DATA_BEATS`, 4: write beats per line. Must be 4, matching the 2-bit offset.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  system clock.
  - `reset`  in  1  synchronous, active-high reset.
- Instruction-cache request channel:
  - `ic_req_valid`  in  1  read request.
  - `ic_req_ready`  out  1  request accepted.
  - `ic_req_addr`  in  MEM_ADDR_BITS  line address.
  - `ic_req_tag`  in  MEM_TAG_BITS-1  client tag.
- Instruction-cache response channel:
  - `ic_resp_valid`  out  1  response to icache.
  - `ic_resp_tag`  out  MEM_TAG_BITS-1  returned tag.
  - `ic_resp_data`  out  MEM_DATA_BITS  returned data.
- Data-cache request channel:
  - `dc_req_valid`  in  1  request.
  - `dc_req_ready`  out  1  request accepted.
  - `dc_req_rw`  in  1  1=write, 0=read.
  - `dc_req_addr`  in  MEM_ADDR_BITS  line address.
  - `dc_req_tag`  in  MEM_TAG_BITS-1  client tag.
- Data-cache write-data channel:
  - `dc_req_data_valid`  in  1  write beat valid.
  - `dc_req_data_ready`  out  1  write beat accepted.
  - `dc_req_data_bits`  in  MEM_DATA_BITS  beat data.
  - `dc_req_data_mask`  in  MEM_DATA_BITS/8  byte mask.
- Data-cache response channel:
  - `dc_resp_valid`  out  1  response to dcache.
  - `dc_resp_tag`  out  MEM_TAG_BITS-1  returned tag.
  - `dc_resp_data`  out  MEM_DATA_BITS  returned data.
- Memory request channel (`mem_*`), to BackupMemory:
  - `mem_req_valid` out, `mem_req_ready` in, `mem_req_rw` out, `mem_req_addr` out, `mem_req_tag` out (MEM_TAG_BITS).
- Memory write-data channel:
  - `mem_req_data_valid` out, `mem_req_data_ready` in, `mem_req_data_bits` out, `mem_req_data_mask` out, `mem_req_data_offset` out (2).
- Memory response channel:
  - `mem_resp_valid` in, `mem_resp_tag` in (MEM_TAG_BITS), `mem_resp_data` in.

## Operation
- Registered state:
  - `state` ∈ {IDLE, WDATA}.
  - `last_grant` (0=ic, 1=dc); reset value 1, so the icache wins the first tie.
  - `beat` counter, 2 bits, reset value 0.
- Grant in IDLE is combinational:
  - Only one client valid: that client.
  - Both valid: the client ≠ `last_grant`.
- IDLE outputs:
  - `mem_req_valid` = `ic_req_valid | dc_req_valid`.
  - `mem_req_rw`/`mem_req_addr` are muxed from the granted client; the icache drives rw=0.
  - `mem_req_tag` = {grant_id, client tag}.
  - Granted client's `*_req_ready` = `mem_req_ready`; the loser's ready = 0.
- On a request handshake (`mem_req_valid & mem_req_ready`): `last_grant` ← grant_id.
  - dc write (rw=1): go to WDATA with `beat`=0.
  - Otherwise stay in IDLE.
- WDATA:
  - `mem_req_valid`, `ic_req_ready`, `dc_req_ready` = 0.
  - `mem_req_data_valid` = `dc_req_data_valid`; `dc_req_data_ready` = `mem_req_data_ready`.
  - bits and mask pass through; `mem_req_data_offset` = `beat`.
  - Each data handshake: `beat` += 1. A handshake with `beat`==DATA_BEATS-1 → IDLE, `beat` wraps to 0.
- IDLE: `mem_req_data_valid` = 0 and `dc_req_data_ready` = 0. Early dc beats are held off, never dropped.
- Responses are stateless and processed in any state:
  - `mem_resp_tag[MSB]`=0 → `ic_resp_valid`=`mem_resp_valid`.
  - MSB=1 → `dc_resp_valid`.
  - Tag low bits and data fan out to both clients unconditionally.
  - A response and a request in the same cycle are independent.
- Reset: while `reset`=1, every valid/ready output is forced 0. The next edge sets state=IDLE, `beat`=0, `last_grant`=1. A write aborted mid-burst is not completed.

## Timing
- Zero-cycle request path: `mem_req_valid` follows the client valid combinationally. The granted client sees ready in the same cycle `mem_req_ready` is high.
- Grant may change only in IDLE and only between handshakes. If the granted client's valid holds, the grant holds until its handshake, even if the other client rises.
- Write occupancy = 1 request cycle + ≥DATA_BEATS data cycles. The first data beat can handshake in the cycle after the request handshake.
- Back-to-back reads from alternating clients: one handshake per cycle.
- Response latency added: 0 cycles.

## Test plan
- Icache read only: ic addr=0x100, tag=3, mem ready=1 → mem_req_tag=0x03, rw=0, ic_req_ready=1 same cycle. A mem response with tag 0x03 → ic_resp_valid=1, tag=3, dc_resp_valid=0.
- Both clients valid for 4 cycles from reset, mem ready=1 → grants ic, dc, ic, dc. mem_req_tag MSB sequence is 0,1,0,1.
- Dc write to 0x40, then 4 beats with mem_req_data_ready toggling 1,0,1,1,1 → offsets 0,1,2,3 appear in order. ic_req_ready stays 0 throughout although ic_req_valid=1. The ic is granted the cycle after the 4th beat.
- Dc data_valid=1 in IDLE with no write outstanding → dc_req_data_ready=0, mem_req_data_valid=0.
- Reset asserted after beat 1 of a write → all ready/valid outputs 0 during reset. After release, a new ic read is granted immediately and beat restarts at 0 for the next write.
- Mem_req_ready=0 for 3 cycles with ic valid, dc rising in cycle 2 → grant stays ic until its handshake, then dc.
